// File: rtl/sweep_capture_ctrl.sv
// Sweep/capture sequencer for the phase-accumulator down-sampler feeding the FFT buffer.
// Programs each control word, resets the down-sampler, skips settling strobes, writes one frame, and waits for the FFT ack.
`timescale 1ns/1ps
module sweep_capture_ctrl #(
  parameter int N_LOG2       = 10,
  parameter int SETTLE_EDGES = 4,
  parameter int RST_CYC      = 2,
  parameter int TIMEOUT      = 1048576
) (
  input  logic              clk_AD,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       fre_base,
  input  logic [31:0]       fre_step,
  input  logic [7:0]        num_steps,
  input  logic              clk_sample,
  input  logic [11:0]       data_in,
  output logic [31:0]       sample_fre,
  output logic              ds_rst_n,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [7:0]        step_idx,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_MAX = (RST_CYC > SETTLE_EDGES) ? RST_CYC : SETTLE_EDGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_EDGES - 1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT - 1);
  localparam logic [N_LOG2-1:0] ADDR_LAST   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SETTLE,
    S_CAPTURE,
    S_WAIT_ACK
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_cs_d, w_cs_d_next;
  logic                r_edge_d, w_edge_d_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [N_LOG2-1:0]   r_addr_cnt, w_addr_cnt_next;
  logic [WD_W-1:0]     r_wdog, w_wdog_next;
  logic [31:0]         r_sample_fre, w_sample_fre_next;
  logic [31:0]         r_fre_step, w_fre_step_next;
  logic [7:0]          r_eff_steps, w_eff_steps_next;
  logic [7:0]          r_step_idx, w_step_idx_next;
  logic                r_ds_rst_n, w_ds_rst_n_next;
  logic                r_wr_en, w_wr_en_next;
  logic [N_LOG2-1:0]   r_wr_addr, w_wr_addr_next;
  logic [11:0]         r_wr_data, w_wr_data_next;
  logic                r_frame_valid, w_frame_valid_next;
  logic                r_timeout_err, w_timeout_err_next;

  logic                w_edge;
  logic                w_watch;
  logic                w_timeout;
  logic                w_last_step;

  assign w_edge      = clk_sample & ~r_cs_d;
  assign w_watch     = (r_state == S_SETTLE) || (r_state == S_CAPTURE);
  assign w_timeout   = w_watch && (r_wdog == WD_LAST);
  assign w_last_step = (({1'b0, r_step_idx} + 9'd1) == {1'b0, r_eff_steps});

  always_ff @(posedge clk_AD) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_AD) begin
    if (!rst_n) begin
      r_cs_d        <= 1'b1;
      r_edge_d      <= 1'b0;
      r_cnt         <= '0;
      r_addr_cnt    <= '0;
      r_wdog        <= '0;
      r_sample_fre  <= '0;
      r_fre_step    <= '0;
      r_eff_steps   <= 8'd1;
      r_step_idx    <= '0;
      r_ds_rst_n    <= 1'b1;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_valid <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cs_d        <= w_cs_d_next;
      r_edge_d      <= w_edge_d_next;
      r_cnt         <= w_cnt_next;
      r_addr_cnt    <= w_addr_cnt_next;
      r_wdog        <= w_wdog_next;
      r_sample_fre  <= w_sample_fre_next;
      r_fre_step    <= w_fre_step_next;
      r_eff_steps   <= w_eff_steps_next;
      r_step_idx    <= w_step_idx_next;
      r_ds_rst_n    <= w_ds_rst_n_next;
      r_wr_en       <= w_wr_en_next;
      r_wr_addr     <= w_wr_addr_next;
      r_wr_data     <= w_wr_data_next;
      r_frame_valid <= w_frame_valid_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cs_d_next        = clk_sample;
    w_edge_d_next      = w_edge;
    w_cnt_next         = r_cnt;
    w_addr_cnt_next    = r_addr_cnt;
    w_wdog_next        = (w_watch && !w_edge) ? (r_wdog + WD_W'(1)) : '0;
    w_sample_fre_next  = r_sample_fre;
    w_fre_step_next    = r_fre_step;
    w_eff_steps_next   = r_eff_steps;
    w_step_idx_next    = r_step_idx;
    w_ds_rst_n_next    = r_ds_rst_n;
    w_wr_en_next       = 1'b0;
    w_wr_addr_next     = r_wr_addr;
    w_wr_data_next     = r_wr_data;
    w_frame_valid_next = r_frame_valid;
    w_timeout_err_next = r_timeout_err;

    if (abort) begin
      // Abort also swallows a coincident start: nothing gets latched.
      w_state_next       = S_IDLE;
      w_ds_rst_n_next    = 1'b1;
      w_frame_valid_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_ds_rst_n_next = 1'b1;
          if (start) begin
            w_sample_fre_next  = fre_base;
            w_fre_step_next    = fre_step;
            w_eff_steps_next   = (num_steps == 8'd0) ? 8'd1 : num_steps;
            w_step_idx_next    = '0;
            w_timeout_err_next = 1'b0;
            w_cnt_next         = '0;
            w_ds_rst_n_next    = 1'b0;
            w_state_next       = S_CONFIG;
          end
        end

        S_CONFIG: begin
          // Forcing the history high masks the strobe line while the down-sampler restarts.
          w_cs_d_next   = 1'b1;
          w_edge_d_next = 1'b0;
          if (r_cnt == RST_LAST) begin
            w_cnt_next      = '0;
            w_ds_rst_n_next = 1'b1;
            w_state_next    = S_SETTLE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end

        S_SETTLE: begin
          if (w_timeout) begin
            w_timeout_err_next = 1'b1;
            w_state_next       = S_IDLE;
          end else if (r_edge_d) begin
            if (r_cnt == SETTLE_LAST) begin
              w_cnt_next      = '0;
              w_addr_cnt_next = '0;
              w_wr_addr_next  = '0;
              w_wdog_next     = '0;
              w_state_next    = S_CAPTURE;
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
        end

        S_CAPTURE: begin
          if (w_timeout) begin
            w_timeout_err_next = 1'b1;
            w_state_next       = S_IDLE;
          end else if (r_edge_d) begin
            w_wr_en_next    = 1'b1;
            w_wr_data_next  = data_in;
            w_wr_addr_next  = r_addr_cnt;
            w_addr_cnt_next = r_addr_cnt + N_LOG2'(1);
            if (r_addr_cnt == ADDR_LAST) begin
              w_frame_valid_next = 1'b1;
              w_state_next       = S_WAIT_ACK;
            end
          end
        end

        S_WAIT_ACK: begin
          if (frame_ack) begin
            w_frame_valid_next = 1'b0;
            if (w_last_step) begin
              w_state_next = S_IDLE;
            end else begin
              w_step_idx_next   = r_step_idx + 8'd1;
              w_sample_fre_next = r_sample_fre + r_fre_step;
              w_cnt_next        = '0;
              w_ds_rst_n_next   = 1'b0;
              w_state_next      = S_CONFIG;
            end
          end
        end

        default: begin
          w_state_next    = S_IDLE;
          w_ds_rst_n_next = 1'b1;
        end
      endcase
    end
  end

  assign sample_fre  = r_sample_fre;
  assign ds_rst_n    = r_ds_rst_n;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_valid = r_frame_valid;
  assign step_idx    = r_step_idx;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sweep_capture_ctrl.sv
// Bench for sweep_capture_ctrl: a phase-accumulator down-sampler model drives strobes and a sample ramp.
// Expected buffer writes are queued by the stimulus and popped by an independent write monitor.
`timescale 1ns/1ps
module tb_sweep_capture_ctrl;

  localparam int N_LOG2 = 4;
  localparam int NWORDS = 16;

  logic        clk_AD = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] fre_base;
  logic [31:0] fre_step;
  logic [7:0]  num_steps;
  logic        clk_sample;
  logic [11:0] data_in;
  logic [31:0] sample_fre;
  logic        ds_rst_n;
  logic        wr_en;
  logic [N_LOG2-1:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_valid;
  logic        frame_ack;
  logic [7:0]  step_idx;
  logic        busy;
  logic        timeout_err;

  sweep_capture_ctrl #(
    .N_LOG2(N_LOG2), .SETTLE_EDGES(4), .RST_CYC(2), .TIMEOUT(64)
  ) dut (
    .clk_AD(clk_AD), .rst_n(rst_n), .start(start), .abort(abort),
    .fre_base(fre_base), .fre_step(fre_step), .num_steps(num_steps),
    .clk_sample(clk_sample), .data_in(data_in), .sample_fre(sample_fre),
    .ds_rst_n(ds_rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .step_idx(step_idx),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_AD = ~clk_AD;

  // Down-sampler model: MSB of the accumulator is the strobe; data_out steps one cycle after it.
  logic [31:0] ds_acc;
  logic [11:0] ds_cnt;
  logic        ds_msb_d;
  always @(posedge clk_AD) begin
    if (!rst_n || !ds_rst_n) begin
      ds_acc   <= '0;
      ds_cnt   <= '0;
      data_in  <= '0;
      ds_msb_d <= 1'b0;
    end else begin
      ds_acc   <= ds_acc + sample_fre;
      ds_msb_d <= ds_acc[31];
      if (ds_acc[31] && !ds_msb_d) begin
        data_in <= ds_cnt;
        ds_cnt  <= ds_cnt + 12'd1;
      end
    end
  end
  assign clk_sample = ds_acc[31];

  int cyc = 0;
  always @(posedge clk_AD) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  typedef struct {
    int          addr;
    int          data;
    logic [31:0] fre;
    int          idx;
    int          gmin;
    int          gmax;
  } wr_exp_t;

  wr_exp_t exp_q[$];

  task automatic push_frame(input logic [31:0] fre, input int idx, input int nw, input int gmin, input int gmax);
    wr_exp_t e;
    for (int a = 0; a < nw; a++) begin
      e.addr = a;
      e.data = 4 + a;
      e.fre  = fre;
      e.idx  = idx;
      e.gmin = (a == 0) ? 0 : gmin;
      e.gmax = gmax;
      exp_q.push_back(e);
    end
  endtask

  // Write monitor / scoreboard
  int      wr_seen     = 0;
  int      last_wr_cyc = 0;
  int      fv_rises    = 0;
  logic    fv_prev     = 1'b0;
  wr_exp_t m_e;
  int      m_gap;
  always @(negedge clk_AD) begin
    if (rst_n && wr_en) begin
      wr_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", wr_addr, wr_data);
      end else begin
        m_e   = exp_q.pop_front();
        m_gap = cyc - last_wr_cyc;
        if (wr_addr == m_e.addr[N_LOG2-1:0] && wr_data == m_e.data[11:0] && sample_fre == m_e.fre &&
            step_idx == m_e.idx[7:0] && (m_e.gmin == 0 || (m_gap >= m_e.gmin && m_gap <= m_e.gmax)))
          n_pass++;
        else
          $display("FAIL write: got addr %0d data %0d fre 0x%0h idx %0d gap %0d, required addr %0d data %0d fre 0x%0h idx %0d gap %0d..%0d",
                   wr_addr, wr_data, sample_fre, step_idx, m_gap, m_e.addr, m_e.data, m_e.fre, m_e.idx, m_e.gmin, m_e.gmax);
      end
      $display("write addr=%0d data=%0d fre=0x%08h idx=%0d", wr_addr, wr_data, sample_fre, step_idx);
      last_wr_cyc = cyc;
    end
    if (frame_valid && !fv_prev) fv_rises++;
    fv_prev = frame_valid;
  end

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] s, input logic [7:0] n);
    @(negedge clk_AD);
    start = 1'b1; fre_base = b; fre_step = s; num_steps = n;
    @(negedge clk_AD);
    start = 1'b0;
  endtask

  task automatic wait_fv(input string name, input int bound);
    int n = 0;
    while (!frame_valid && n < bound) begin
      @(negedge clk_AD);
      n++;
    end
    check(name, {31'd0, frame_valid}, 32'd1);
    @(negedge clk_AD);
  endtask

  task automatic do_ack();
    @(negedge clk_AD);
    frame_ack = 1'b1;
    @(negedge clk_AD);
    frame_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got still running, required finished");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    int base_seen;
    int fv_before;
    logic [31:0] held_fre;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_ack = 1'b0;
    fre_base = '0; fre_step = '0; num_steps = '0;
    repeat (3) @(negedge clk_AD);
    check("rst_sample_fre", sample_fre, 32'd0);
    check("rst_ds_rst_n",   {31'd0, ds_rst_n}, 32'd1);
    check("rst_outs_low",   {27'd0, wr_en, frame_valid, busy, timeout_err, |wr_addr}, 32'd0);
    check("rst_data_idx",   {12'd0, wr_data, step_idx}, 32'd0);
    rst_n = 1'b1;

    // Single frame at Fs = clk/4; an early ack outside WAIT_ACK is ignored
    push_frame(32'h4000_0000, 0, NWORDS, 4, 4);
    pulse_start(32'h4000_0000, 32'h0, 8'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (ds_rst_n == 1'b0 && n < 20) begin
      @(negedge clk_AD);
      n++;
    end
    check("t1_ds_rst_low_cycles", n, 2);
    repeat (20) @(negedge clk_AD);
    do_ack();
    check("t1_early_ack_ignored", {30'd0, busy, frame_valid}, 32'd2);
    wait_fv("t1_frame_valid", 300);
    check("t1_all_writes_seen", exp_q.size(), 0);
    do_ack();
    check("t1_idle_after_ack", {30'd0, busy, frame_valid}, 32'd0);
    check("t1_fre_held", sample_fre, 32'h4000_0000);

    // Three-frame sweep, with a long-held ack on the first frame
    push_frame(32'h1000_0000, 0, NWORDS, 16, 16);
    push_frame(32'h2000_0000, 1, NWORDS, 8, 8);
    push_frame(32'h3000_0000, 2, NWORDS, 5, 6);
    pulse_start(32'h1000_0000, 32'h1000_0000, 8'd3);
    wait_fv("t2_frame0_valid", 1000);
    held_fre = sample_fre;
    bad = 0;
    repeat (100) begin
      @(negedge clk_AD);
      if (!frame_valid || wr_en || sample_fre !== held_fre) bad++;
    end
    check("t3_hold_stable", bad, 0);
    check("t3_step_idx0", step_idx, 32'd0);
    do_ack();
    check("t3_reconfig", {30'd0, busy, ds_rst_n}, 32'd2);
    check("t2_fre1", sample_fre, 32'h2000_0000);
    check("t2_idx1", step_idx, 32'd1);
    wait_fv("t2_frame1_valid", 600);
    do_ack();
    check("t2_fre2", sample_fre, 32'h3000_0000);
    check("t2_idx2", step_idx, 32'd2);
    wait_fv("t2_frame2_valid", 400);
    do_ack();
    check("t2_idle", {31'd0, busy}, 32'd0);
    check("t2_all_writes_seen", exp_q.size(), 0);

    // Zero control word: no strobes, watchdog fires in SETTLE
    pulse_start(32'h0, 32'h0, 8'd1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk_AD);
      n++;
    end
    check("t4_timeout_cycles", n, 66);
    check("t4_timeout_err", {30'd0, timeout_err, busy}, 32'd2);

    // New start clears the error; start while busy ignored; abort after 5 writes
    push_frame(32'h4000_0000, 0, 5, 4, 4);
    base_seen = wr_seen;
    fv_before = fv_rises;
    pulse_start(32'h4000_0000, 32'h0, 8'd1);
    check("t4_err_cleared", {31'd0, timeout_err}, 32'd0);
    repeat (8) @(negedge clk_AD);
    pulse_start(32'h7000_0000, 32'h1, 8'd5);
    check("t5_busy_start_ignored", sample_fre, 32'h4000_0000);
    n = 0;
    while (wr_seen < base_seen + 5 && n < 400) begin
      @(negedge clk_AD);
      n++;
    end
    abort = 1'b1;
    @(negedge clk_AD);
    abort = 1'b0;
    check("t5_abort_idle", {29'd0, busy, wr_en, ds_rst_n}, 32'd1);
    check("t5_abort_fre_held", sample_fre, 32'h4000_0000);
    repeat (40) @(negedge clk_AD);
    check("t5_write_count", wr_seen - base_seen, 5);
    check("t5_no_frame_valid", fv_rises - fv_before, 0);

    // Abort and start together in IDLE: start dropped
    @(negedge clk_AD);
    start = 1'b1; abort = 1'b1; fre_base = 32'h5555_5555; num_steps = 8'd1;
    @(negedge clk_AD);
    start = 1'b0; abort = 1'b0;
    check("t5_abort_beats_start", {31'd0, busy}, 32'd0);
    check("t5_abort_start_fre", sample_fre, 32'h4000_0000);

    // Control word wrap, then num_steps=0 as a single frame
    push_frame(32'hF000_0000, 0, NWORDS, 16, 16);
    push_frame(32'h1000_0000, 1, NWORDS, 16, 16);
    pulse_start(32'hF000_0000, 32'h2000_0000, 8'd2);
    wait_fv("t6_frame0_valid", 1000);
    do_ack();
    check("t6_wrap_fre", sample_fre, 32'h1000_0000);
    wait_fv("t6_frame1_valid", 1000);
    do_ack();
    check("t6_idle", {31'd0, busy}, 32'd0);
    push_frame(32'h4000_0000, 0, NWORDS, 4, 4);
    pulse_start(32'h4000_0000, 32'h0, 8'd0);
    wait_fv("t6_zero_steps_valid", 300);
    do_ack();
    check("t6_zero_steps_one_frame", {31'd0, busy}, 32'd0);

    // Reset in the middle of a sweep
    pulse_start(32'h1000_0000, 32'h0, 8'd1);
    repeat (20) @(negedge clk_AD);
    rst_n = 1'b0;
    @(negedge clk_AD);
    check("midrst_fre", sample_fre, 32'd0);
    check("midrst_outs", {29'd0, busy, ds_rst_n, frame_valid}, 32'd2);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_AD);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sweep_capture_ctrl.md
Name: sweep_capture_ctrl

Overview:
- Sequences the phase-accumulator down-sampler for FFT acquisition.
- Programs its 32-bit sample-rate control word, pulses its reset, discards settling samples, then writes N consecutive down-sampled words into the FFT input buffer.
- Hands each frame to the FFT with a valid/ack handshake.
- Steps the control word through a linear sweep (base + k*step) for a programmed number of frames.

Parameters:
- N_LOG2, 10, log2 of samples per frame (1024).
- SETTLE_EDGES, 4, sample strobes discarded after each reprogram.
- RST_CYC, 2, clk_AD cycles ds_rst_n is held low per reprogram.
- TIMEOUT, 1048576, max clk_AD cycles without a sample strobe in SETTLE/CAPTURE.

Ports:
- clk_AD  in  1  AD master clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  level; forces return to IDLE.
- fre_base  in  32  first control word; latched on accepted start.
- fre_step  in  32  increment per frame; latched on accepted start.
- num_steps  in  8  frames per sweep; latched on start, 0 treated as 1.
- clk_sample  in  1  strobe clock from down-sampler.
- data_in  in  12  down-sampler data_out.
- sample_fre  out  32  control word to down-sampler.
- ds_rst_n  out  1  down-sampler reset, active-low.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  N_LOG2  buffer write address.
- wr_data  out  12  buffer write data.
- frame_valid  out  1  frame complete, held until frame_ack.
- frame_ack  in  1  FFT consumed frame.
- step_idx  out  8  current frame index (0-based).
- busy  out  1  high in any state but IDLE.
- timeout_err  out  1  sticky; cleared by accepted start or reset.

Behaviour:
- Reset values: sample_fre=0, ds_rst_n=1, wr_en=0, wr_addr=0, wr_data=0, frame_valid=0, step_idx=0, busy=0, timeout_err=0, state IDLE.
- Strobe detect: cs_d <= clk_sample; edge = clk_sample & ~cs_d; edge_d <= edge.
  - Down-sampler data_out is valid on the cycle after its own edge, so sampling uses edge_d (data_in registered on edge_d).
- States:
  - IDLE: on start, latch inputs, sample_fre <= fre_base, step_idx <= 0, timeout_err <= 0, go CONFIG. start while busy is ignored.
  - CONFIG: ds_rst_n=0 for exactly RST_CYC cycles; clear strobe history (cs_d <= 1 so no false edge); go SETTLE.
  - SETTLE: count SETTLE_EDGES edge_d events without writing; go CAPTURE.
  - CAPTURE: on each edge_d, wr_en=1 for one cycle, wr_data=data_in, wr_addr=count.
    - After the write with wr_addr=2^N_LOG2-1, go WAIT_ACK and set frame_valid.
    - Write latency is 1 cycle after edge_d (registered outputs).
  - WAIT_ACK: frame_valid held high until frame_ack sampled high, then frame_valid <= 0.
    - If step_idx+1 == eff_steps, go IDLE.
    - Otherwise step_idx++, sample_fre <= sample_fre + fre_step (mod 2^32 wrap), go CONFIG.
  - frame_ack asserted outside WAIT_ACK is ignored.
- Watchdog: counter reset on each edge and on state entry. Reaching TIMEOUT in SETTLE or CAPTURE sets timeout_err and goes IDLE with wr_en=0. This covers sample_fre=0, which produces no strobes.
- Abort: IDLE on the next edge from any state; ds_rst_n=1, wr_en=0, frame_valid=0; sample_fre holds last value; timeout_err unchanged.
- Abort and start in the same cycle in IDLE: abort wins, start is dropped.
- rst_n low mid-operation: all outputs return to reset values on that edge.
- wr_addr wraps to 0 at frame start. No partial frame is flagged valid.

Test Plan:
1. fre_base=0x4000_0000 (Fs=clk/4), num_steps=1, N_LOG2=4 for sim, data_in ramp.
   -> ds_rst_n low 2 cycles, 4 strobes skipped, 16 writes spaced 4 cycles with addr 0..15, frame_valid; ack -> busy=0.
2. num_steps=3, base=0x1000_0000, step=0x1000_0000.
   -> three frames with sample_fre 0x1000_0000, 0x2000_0000, 0x3000_0000; step_idx 0,1,2; write spacing 16, 8, ~5.33 cycles.
3. Hold frame_ack low 100 cycles after frame.
   -> frame_valid stays high, no writes, sample_fre unchanged; ack -> next CONFIG.
4. fre_base=0, TIMEOUT=64.
   -> after 64 strobe-free cycles in SETTLE, timeout_err=1, busy=0; a new start clears it.
5. abort mid-CAPTURE after 5 writes.
   -> next cycle IDLE, wr_en=0, frame_valid never asserted; start pulse while busy (before abort) is ignored.
6. base=0xF000_0000, step=0x2000_0000, num_steps=2.
   -> second word 0x1000_0000 (wrap). num_steps=0 -> exactly one frame.
